gpu_cmd_sequencer: RTL



---
 rtl/gpu_cmd_pkg.sv | 17 +
 rtl/gpu_buf_tracker.sv | 49 ++++
 rtl/gpu_cmd_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gpu_cmd_pkg.sv
// Shared constants for the GPU command front-end.
package gpu_cmd_pkg;

  // Command address that selects the control-opcode path.
  localparam int unsigned CTRL_ADDR = 0;

  // Control opcodes carried in cmd_data[3:0] when cmd_addr == CTRL_ADDR.
  typedef enum logic [3:0] {
    OP_START_TILE  = 4'd0,
    OP_NOP         = 4'd1,
    OP_START_WRITE = 4'd2,
    OP_FLUSH       = 4'd4,
    OP_RESET       = 4'd5,
    OP_FENCE       = 4'd6
  } opcode_e;

endpackage

// File: rtl/gpu_buf_tracker.sv
// Tile-buffer rotation: render/write buffer indices and in-flight occupancy.
module gpu_buf_tracker #(
  parameter int NUM_BUFS = 2,
  parameter int BUF_W    = $clog2(NUM_BUFS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             write_ready,
  input  logic             write_release,
  output logic [BUF_W-1:0] render_buf,
  output logic [BUF_W-1:0] write_buf,
  output logic             can_write,
  output logic             idle
);

  localparam logic [BUF_W-1:0] LAST = BUF_W'(NUM_BUFS - 1);

  logic [BUF_W-1:0] in_flight;
  logic             release_ok;

  // At most NUM_BUFS-1 buffers may sit with the writer; one stays with the renderer.
  always_comb begin
    release_ok = write_release && (in_flight != '0);
    can_write  = write_ready && (in_flight < LAST);
    idle       = (in_flight == '0);
  end

  // Rotate buffers on each handed-off tile and track writer occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      render_buf <= '0;
      write_buf  <= '0;
      in_flight  <= '0;
    end else begin
      if (advance) begin
        write_buf  <= render_buf;
        render_buf <= (render_buf == LAST) ? '0 : render_buf + BUF_W'(1);
      end
      // Hand-off and release in the same cycle cancel out.
      case ({advance, release_ok})
        2'b10:   in_flight <= in_flight + BUF_W'(1);
        2'b01:   in_flight <= in_flight - BUF_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmd_sequencer.sv
// GPU command front-end: retires {addr, data} commands, forwards register
// writes, dispatches control opcodes with per-opcode stall rules.
module gpu_cmd_sequencer
  import gpu_cmd_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int NUM_BUFS = 2,
  parameter int SEQ_W    = 32,
  parameter int BUF_W    = $clog2(NUM_BUFS)
) (
  input  logic              gpu_clk,
  input  logic              gpu_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_idx,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              tile_start,
  output logic              tile_clear,
  input  logic              tile_done,
  output logic [BUF_W-1:0]  render_buf,
  output logic              write_start,
  output logic [BUF_W-1:0]  write_buf,
  input  logic              write_ready,
  input  logic              write_release,
  input  logic              write_flushed,
  output logic              fence_pulse,
  output logic [DATA_W-5:0] fence_tag,
  output logic [SEQ_W-1:0]  seq_no,
  output logic [7:0]        err_count,
  output logic              busy
);

  opcode_e op;
  logic    is_ctrl;
  logic    retire;
  logic    can_write;
  logic    bufs_idle;
  logic    clear_flag;
  logic    do_reg, do_tile, do_write, do_reset, do_fence, do_unknown;

  // Head-command decode and stall rules; no command is accepted during reset.
  always_comb begin
    is_ctrl   = (cmd_addr == ADDR_W'(CTRL_ADDR));
    op        = opcode_e'(cmd_data[3:0]);
    cmd_ready = 1'b0;
    if (!gpu_rst) begin
      if (!is_ctrl) begin
        cmd_ready = 1'b1;
      end else begin
        case (op)
          OP_START_TILE:  cmd_ready = tile_done;
          OP_START_WRITE: cmd_ready = tile_done && can_write;
          OP_FLUSH:       cmd_ready = write_flushed && bufs_idle;
          OP_FENCE:       cmd_ready = tile_done && write_flushed && bufs_idle;
          default:        cmd_ready = 1'b1;
        endcase
      end
    end
    retire     = cmd_valid && cmd_ready;
    do_reg     = retire && !is_ctrl;
    do_tile    = retire && is_ctrl && (op == OP_START_TILE);
    do_write   = retire && is_ctrl && (op == OP_START_WRITE);
    do_reset   = retire && is_ctrl && (op == OP_RESET);
    do_fence   = retire && is_ctrl && (op == OP_FENCE);
    do_unknown = 1'b0;
    if (retire && is_ctrl) begin
      case (op)
        OP_START_TILE, OP_NOP, OP_START_WRITE,
        OP_FLUSH, OP_RESET, OP_FENCE: do_unknown = 1'b0;
        default:                      do_unknown = 1'b1;
      endcase
    end
    busy = cmd_valid && !cmd_ready;
  end

  gpu_buf_tracker #(
    .NUM_BUFS (NUM_BUFS),
    .BUF_W    (BUF_W)
  ) u_buf_tracker (
    .clk           (gpu_clk),
    .rst           (gpu_rst),
    .advance       (do_write),
    .write_ready   (write_ready),
    .write_release (write_release),
    .render_buf    (render_buf),
    .write_buf     (write_buf),
    .can_write     (can_write),
    .idle          (bufs_idle)
  );

  // Registered command effects: one-cycle pulses, clear flag, counters.
  always_ff @(posedge gpu_clk) begin
    if (gpu_rst) begin
      reg_we      <= 1'b0;
      reg_idx     <= '0;
      reg_wdata   <= '0;
      tile_start  <= 1'b0;
      tile_clear  <= 1'b0;
      write_start <= 1'b0;
      fence_pulse <= 1'b0;
      fence_tag   <= '0;
      clear_flag  <= 1'b1;
      seq_no      <= '0;
      err_count   <= '0;
    end else begin
      reg_we      <= do_reg;
      tile_start  <= do_tile;
      tile_clear  <= do_tile && clear_flag;
      write_start <= do_write;
      fence_pulse <= do_fence;
      if (do_reg) begin
        reg_idx   <= cmd_addr;
        reg_wdata <= cmd_data;
      end
      if (do_fence) fence_tag <= cmd_data[DATA_W-1:4];
      if (do_write || do_reset) clear_flag <= 1'b1;
      else if (do_tile)         clear_flag <= 1'b0;
      if (do_reset)    seq_no <= '0;
      else if (retire) seq_no <= seq_no + SEQ_W'(1);
      if (do_unknown && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule
